// File: rtl/pds_pkg.sv
// Shared types and elaboration helpers for the power-domain sequencer.
package pds_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PWR_UP   = 3'd1,
    ST_RELEASE  = 3'd2,
    ST_ISOLATE  = 3'd3,
    ST_PWR_DOWN = 3'd4
  } pds_state_e;

  // Index width for n domains; never narrower than one bit.
  function automatic int IDX_W(input int n);
    return (n < 32'sd2) ? 32'sd1 : $clog2(n);
  endfunction

  function automatic bit pds_params_legal(input int num_domains, input int wake_cycles,
                                          input int sleep_cycles, input int cnt_w);
    return (num_domains >= 32'sd2) && (num_domains <= 32'sd16) &&
           (wake_cycles >= 32'sd1) && (sleep_cycles >= 32'sd1) &&
           (cnt_w >= 32'sd1) && (cnt_w <= 32'sd30) &&
           (wake_cycles < (32'sd1 << cnt_w)) && (sleep_cycles < (32'sd1 << cnt_w));
  endfunction

endpackage

// File: rtl/pds_rr_arbiter.sv
// Combinational round-robin picker: first set bit of pending_i at or after ptr_i,
// wrapping modulo N.
module pds_rr_arbiter
#(
  parameter int N  = 4,
  parameter int IW = 2
)(
  input  logic [N-1:0]  pending_i,
  input  logic [IW-1:0] ptr_i,
  output logic          grant_valid_o,
  output logic [IW-1:0] grant_idx_o
);

  logic [IW-1:0] cand_s;

  // Scan from the farthest offset down so the nearest pending index wins.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    cand_s        = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand_s        = IW'((int'(ptr_i) + k) % N);
      grant_valid_o = grant_valid_o | pending_i[cand_s];
      grant_idx_o   = pending_i[cand_s] ? cand_s : grant_idx_o;
    end
  end

endmodule

// File: rtl/power_domain_sequencer_chk.sv
// Ordering invariants of the sequencer outputs: unclamp only when powered,
// ready only when unclamped, and at most one switch moved per sequence.
module power_domain_sequencer_chk
#(
  parameter int N = 4
)(
  input logic         clk,
  input logic         rst,
  input logic [N-1:0] sw_en_i,
  input logic [N-1:0] iso_i,
  input logic [N-1:0] ready_i,
  input logic         busy_i
);

  logic [N-1:0] snap_q;

  // Switch state as it was before the current grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= '0;
    end else if (!busy_i) begin
      snap_q <= sw_en_i;
    end else begin
      snap_q <= snap_q;
    end
  end

  a_iso_needs_power : assert property (@(posedge clk) disable iff (rst)
    (~iso_i & ~sw_en_i) == '0);

  a_ready_needs_unclamp : assert property (@(posedge clk) disable iff (rst)
    (ready_i & iso_i) == '0);

  a_single_switch : assert property (@(posedge clk) disable iff (rst)
    $countones(sw_en_i ^ snap_q) <= 1);

endmodule

// File: rtl/power_domain_sequencer.sv
// Serialises power-up/power-down of gated domains, one at a time, driving
// switch, isolation and ready in a safe order with programmed settle times.
module power_domain_sequencer
  import pds_pkg::*;
#(
  parameter int NUM_DOMAINS  = 4,
  parameter int WAKE_CYCLES  = 16,
  parameter int SLEEP_CYCLES = 4,
  parameter int CNT_W        = 8
)(
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_DOMAINS-1:0]           want_on_i,
  output logic [NUM_DOMAINS-1:0]           sw_en_o,
  output logic [NUM_DOMAINS-1:0]           iso_o,
  output logic [NUM_DOMAINS-1:0]           ready_o,
  output logic                             busy_o,
  output logic [IDX_W(NUM_DOMAINS)-1:0]    active_idx_o
);

  localparam int IW = IDX_W(NUM_DOMAINS);

  if (!pds_params_legal(NUM_DOMAINS, WAKE_CYCLES, SLEEP_CYCLES, CNT_W)) begin : g_param_err
    $error("power_domain_sequencer: illegal parameter combination");
  end

  pds_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   dir_q, dir_d;
  logic                   grant_q, grant_d;
  logic [NUM_DOMAINS-1:0] sw_q, sw_d;
  logic [NUM_DOMAINS-1:0] iso_q, iso_d;
  logic [NUM_DOMAINS-1:0] rdy_q, rdy_d;
  logic                   busy_q, busy_d;

  logic [NUM_DOMAINS-1:0] active_oh_s;
  logic [NUM_DOMAINS-1:0] pending_s;
  logic                   in_flight_s;
  logic                   gnt_valid_s;
  logic [IW-1:0]          gnt_idx_s;

  // Pending set: level mismatch, plus the domain currently held by the sequence.
  always_comb begin
    active_oh_s        = '0;
    active_oh_s[idx_q] = 1'b1;
    in_flight_s        = (state_q != ST_IDLE) || grant_q;
    pending_s          = (want_on_i ^ rdy_q) | (in_flight_s ? active_oh_s : '0);
  end

  pds_rr_arbiter #(
    .N  (NUM_DOMAINS),
    .IW (IW)
  ) u_arb (
    .pending_i     (pending_s),
    .ptr_i         (ptr_q),
    .grant_valid_o (gnt_valid_s),
    .grant_idx_o   (gnt_idx_s)
  );

  // Next-state and per-domain output sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    grant_d = grant_q;
    sw_d    = sw_q;
    iso_d   = iso_q;
    rdy_d   = rdy_q;
    case (state_q)
      ST_IDLE: begin
        // A grant is latched for one cycle before the first output moves.
        if (grant_q) begin
          grant_d = 1'b0;
          if (dir_q) begin
            state_d     = ST_PWR_UP;
            sw_d[idx_q] = 1'b1;
            cnt_d       = CNT_W'(WAKE_CYCLES - 1);
          end else begin
            state_d      = ST_ISOLATE;
            rdy_d[idx_q] = 1'b0;
            iso_d[idx_q] = 1'b1;
          end
        end else if (gnt_valid_s) begin
          grant_d = 1'b1;
          idx_d   = gnt_idx_s;
          dir_d   = want_on_i[gnt_idx_s];
          ptr_d   = (gnt_idx_s == IW'(NUM_DOMAINS - 1)) ? '0 : gnt_idx_s + IW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PWR_UP: begin
        if (cnt_q == '0) begin
          state_d      = ST_RELEASE;
          iso_d[idx_q] = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        state_d      = ST_IDLE;
        rdy_d[idx_q] = 1'b1;
      end
      ST_ISOLATE: begin
        state_d     = ST_PWR_DOWN;
        sw_d[idx_q] = 1'b0;
        cnt_d       = CNT_W'(SLEEP_CYCLES - 1);
      end
      ST_PWR_DOWN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops every switch at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      grant_q <= 1'b0;
      sw_q    <= '0;
      iso_q   <= '1;
      rdy_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      grant_q <= grant_d;
      sw_q    <= sw_d;
      iso_q   <= iso_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign sw_en_o      = sw_q;
  assign iso_o        = iso_q;
  assign ready_o      = rdy_q;
  assign busy_o       = busy_q;
  assign active_idx_o = idx_q;

endmodule

// File: doc/power_domain_sequencer.md
Name: power_domain_sequencer

Overview:
- Sequences power-gating of NUM_DOMAINS standard-cell power domains, e.g. INV/AND cell clusters behind header switches.
- Only one domain transitions at a time, which bounds inrush current and the thermal transient.
- Each domain declares a desired state. The sequencer picks a mismatching domain round-robin and drives the isolation/switch/ready ordering with programmed settle times.
- Sits between the power-management software registers and the switch/isolation cells of the netlist.

Parameters:
- NUM_DOMAINS, 4, number of gated domains (2..16).
- WAKE_CYCLES, 16, cycles switch must be on before isolation release (>=1).
- SLEEP_CYCLES, 4, cycles after switch-off before next grant (>=1).
- CNT_W, 8, settle-counter width; WAKE_CYCLES and SLEEP_CYCLES must be < 2**CNT_W.

Ports:
- clk, input, 1, sole clock; all state on rising edge.
- rst, input, 1, synchronous active-high reset.
- want_on, input, NUM_DOMAINS, desired state per domain (1 = powered); level, sampled every cycle.
- sw_en, output, NUM_DOMAINS, header switch enable per domain.
- iso, output, NUM_DOMAINS, isolation clamp enable per domain (1 = clamped).
- ready, output, NUM_DOMAINS, domain powered and unisolated.
- busy, output, 1, a transition is in progress (state != IDLE).
- active_idx, output, clog2(NUM_DOMAINS), domain currently being sequenced; holds last value when idle.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values:
  - sw_en = 0, iso = all 1, ready = 0, busy = 0, active_idx = 0.
  - RR pointer = 0, state = IDLE.
  - All domains are treated as off.
- All outputs are registered.
- Pending set: domain i is pending when want_on[i] != ready[i], or when it is mid-transition.
- States: IDLE, PWR_UP, RELEASE, ISOLATE, PWR_DOWN.
- IDLE:
  - If any domain is pending, grant the first pending index at or after the RR pointer, wrapping modulo NUM_DOMAINS.
  - Load active_idx and set RR pointer = grant+1 (wraps).
  - Direction = want_on[grant] sampled in this cycle.
  - A grant is possible in every IDLE cycle. No pending domain -> stay in IDLE.
- Wake (grant at edge T, want=1):
  - T+1: sw_en[i] = 1, busy = 1, enter PWR_UP, counter = WAKE_CYCLES-1.
  - PWR_UP decrements to 0, then RELEASE.
  - T+1+WAKE_CYCLES: iso[i] = 0.
  - T+2+WAKE_CYCLES: ready[i] = 1, state IDLE, busy = 0.
- Sleep (grant at T, want=0):
  - T+1: ready[i] = 0, iso[i] = 1, enter ISOLATE.
  - T+2: sw_en[i] = 0, enter PWR_DOWN, counter = SLEEP_CYCLES-1.
  - Return to IDLE at T+2+SLEEP_CYCLES with busy = 0.
- Ordering invariants, checked by assertion:
  - iso[i] = 0 implies sw_en[i] = 1.
  - ready[i] implies iso[i] = 0.
  - At most one domain has sw_en differing from its pre-grant value at any time.
- Mid-operation change: want_on toggles during a transition are ignored until the sequence completes. If a mismatch remains, the domain re-enters the pending set and competes again round-robin; it gets no priority.
- Simultaneous requests: wake and sleep requests are treated identically and served strictly round-robin.
- Reset mid-operation: outputs force to reset values at the next edge, i.e. all switches drop in one cycle. This is accepted, since reset is system-level.
- Non-granted domains hold sw_en/iso/ready unchanged.

Decomposition:
- Package pds_pkg holds:
  - the state enum (IDLE, PWR_UP, RELEASE, ISOLATE, PWR_DOWN);
  - the IDX_W function, clog2 of NUM_DOMAINS;
  - parameter legality checks.
- Sub-module pds_rr_arbiter (combinational): inputs are the pending vector and the pointer; outputs are grant_valid and grant_idx. It is reusable by other resource schedulers.
- FSM, counter and per-domain output registers stay in the top module.

Test Plan:
- Reset then idle: rst for 3 cycles, want_on = 0 -> sw_en = 0, iso = 4'hF, ready = 0, busy = 0 for 20 cycles.
- Single wake: want_on = 4'b0100 at T -> sw_en[2] rises at T+1, iso[2] falls at T+17, ready[2] rises at T+18, busy low at T+18.
- Single sleep: from domain 2 on, want_on = 0 at T -> ready[2]/iso[2] change at T+1, sw_en[2] falls at T+2, busy low at T+6.
- Round-robin fairness: want_on = 4'hF from all-off -> domains woken in order 0, 1, 2, 3. Each ready is exactly 19 cycles apart; sw_en is never rising in two domains within the same 18-cycle window.
- Mixed with wrap:
  - Setup: domains 0 and 3 on, pointer = 3.
  - Stimulus: want_on = 4'b0110.
  - Service order: 3 (sleep), then 0 (sleep), then 1 (wake), then 2 (wake).
- Mid-op toggle and reset:
  - Case 1: drop want_on[1] during its PWR_UP -> the wake completes (ready[1] = 1), then an immediate sleep sequence starts on domain 1.
  - Case 2: separately, assert rst in PWR_UP -> the next edge shows all reset values.
